// File: rtl/pong_game_engine.sv
// pong_game_engine: frame-rate game state for the pong renderer.
// Owns paddle, ball and score registers and the serve/play/point/game-over
// sequencing. Everything advances only on refresh_tick.
module pong_game_engine #(
  parameter int PADDLE_VEL  = 3,
  parameter int BALL_VEL    = 2,
  parameter int POINT_DELAY = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       btn_left_up,
  input  logic       btn_left_down,
  input  logic       btn_right_up,
  input  logic       btn_right_down,
  input  logic       serve,
  output logic [9:0] paddle_left_pos,
  output logic [9:0] paddle_right_pos,
  output logic [9:0] ball_pos_x,
  output logic [9:0] ball_pos_y,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] game_state
);

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    PLAY      = 2'd1,
    POINT     = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  // Geometry, all in 11 bits so that subtraction near zero cannot wrap.
  localparam logic [10:0] PVEL        = 11'(PADDLE_VEL);
  localparam logic [10:0] BVEL        = 11'(BALL_VEL);
  localparam logic [10:0] PADDLE_MAX  = 11'd430;
  localparam logic [10:0] PADDLE_H    = 11'd50;
  localparam logic [10:0] BALL_SIZE   = 11'd10;
  localparam logic [10:0] BALL_Y_MAX  = 11'd470;
  localparam logic [10:0] LEFT_STOP   = 11'd16;
  localparam logic [10:0] RIGHT_STOP  = 11'd610;
  localparam logic [10:0] RIGHT_EDGE  = 11'd630;
  localparam logic [9:0]  PADDLE_HOME = 10'd215;
  localparam logic [9:0]  BALL_X0     = 10'd315;
  localparam logic [9:0]  BALL_Y0     = 10'd235;
  localparam logic [3:0]  WIN         = 4'(WIN_SCORE);
  localparam int          CW          = (POINT_DELAY > 1) ? $clog2(POINT_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(POINT_DELAY - 1);

  state_t        state_q, state_d;
  logic [9:0]    pl_q, pl_d, pr_q, pr_d;
  logic [9:0]    bx_q, bx_d, by_q, by_d;
  logic [3:0]    sl_q, sl_d, sr_q, sr_d;
  logic          dir_right_q, dir_right_d;
  logic          dir_down_q, dir_down_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [10:0]   x_ext, y_ext, pl_ext, pr_ext;
  logic          ov_left, ov_right;

  // One frame of paddle motion, clamped to the screen.
  function automatic logic [9:0] paddle_step(input logic [9:0] pos,
                                             input logic up, input logic down);
    logic [10:0] p;
    p = {1'b0, pos};
    if (up && !down)
      p = (p > PVEL) ? p - PVEL : 11'd0;
    else if (down && !up)
      p = (p + PVEL > PADDLE_MAX) ? PADDLE_MAX : p + PVEL;
    return 10'(p);
  endfunction

  // Next-state and next-frame values; dir_right at the moment of a miss also
  // records who scored (moving right means the left player scored).
  always_comb begin
    state_d     = state_q;
    pl_d        = pl_q;
    pr_d        = pr_q;
    bx_d        = bx_q;
    by_d        = by_q;
    sl_d        = sl_q;
    sr_d        = sr_q;
    dir_right_d = dir_right_q;
    dir_down_d  = dir_down_q;
    cnt_d       = cnt_q;

    x_ext    = {1'b0, bx_q};
    y_ext    = {1'b0, by_q};
    pl_ext   = {1'b0, pl_q};
    pr_ext   = {1'b0, pr_q};
    ov_left  = (y_ext + BALL_SIZE > pl_ext) && (y_ext < pl_ext + PADDLE_H);
    ov_right = (y_ext + BALL_SIZE > pr_ext) && (y_ext < pr_ext + PADDLE_H);

    case (state_q)
      SERVE: begin
        pl_d = paddle_step(pl_q, btn_left_up, btn_left_down);
        pr_d = paddle_step(pr_q, btn_right_up, btn_right_down);
        if (serve)
          state_d = PLAY;
      end

      PLAY: begin
        pl_d = paddle_step(pl_q, btn_left_up, btn_left_down);
        pr_d = paddle_step(pr_q, btn_right_up, btn_right_down);

        if (!dir_down_q) begin
          if (y_ext <= BVEL) begin
            by_d       = '0;
            dir_down_d = 1'b1;
          end else begin
            by_d = 10'(y_ext - BVEL);
          end
        end else begin
          if (y_ext + BVEL >= BALL_Y_MAX) begin
            by_d       = 10'(BALL_Y_MAX);
            dir_down_d = 1'b0;
          end else begin
            by_d = 10'(y_ext + BVEL);
          end
        end

        if (!dir_right_q) begin
          if (x_ext >= LEFT_STOP && x_ext <= LEFT_STOP + BVEL && ov_left) begin
            bx_d        = 10'(LEFT_STOP);
            dir_right_d = 1'b1;
          end else if (x_ext <= BVEL) begin
            state_d = POINT;
            cnt_d   = '0;
            if (sr_q < WIN)
              sr_d = sr_q + 4'd1;
          end else begin
            bx_d = 10'(x_ext - BVEL);
          end
        end else begin
          if (x_ext >= RIGHT_STOP - BVEL && x_ext <= RIGHT_STOP && ov_right) begin
            bx_d        = 10'(RIGHT_STOP);
            dir_right_d = 1'b0;
          end else if (x_ext + BVEL >= RIGHT_EDGE) begin
            state_d = POINT;
            cnt_d   = '0;
            if (sl_q < WIN)
              sl_d = sl_q + 4'd1;
          end else begin
            bx_d = 10'(x_ext + BVEL);
          end
        end
      end

      POINT: begin
        if (cnt_q == CNT_LAST) begin
          if ((dir_right_q ? sl_q : sr_q) == WIN) begin
            state_d = GAME_OVER;
          end else begin
            state_d    = SERVE;
            bx_d       = BALL_X0;
            by_d       = BALL_Y0;
            dir_down_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      GAME_OVER: begin
        if (serve) begin
          state_d    = SERVE;
          sl_d       = '0;
          sr_d       = '0;
          pl_d       = PADDLE_HOME;
          pr_d       = PADDLE_HOME;
          bx_d       = BALL_X0;
          by_d       = BALL_Y0;
          dir_down_d = 1'b1;
        end
      end

      default: state_d = SERVE;
    endcase
  end

  // Frame registers: reset wins, otherwise load only on refresh_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SERVE;
      pl_q        <= PADDLE_HOME;
      pr_q        <= PADDLE_HOME;
      bx_q        <= BALL_X0;
      by_q        <= BALL_Y0;
      sl_q        <= '0;
      sr_q        <= '0;
      dir_right_q <= 1'b1;
      dir_down_q  <= 1'b1;
      cnt_q       <= '0;
    end else if (refresh_tick) begin
      state_q     <= state_d;
      pl_q        <= pl_d;
      pr_q        <= pr_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      sl_q        <= sl_d;
      sr_q        <= sr_d;
      dir_right_q <= dir_right_d;
      dir_down_q  <= dir_down_d;
      cnt_q       <= cnt_d;
    end
  end

  assign paddle_left_pos  = pl_q;
  assign paddle_right_pos = pr_q;
  assign ball_pos_x       = bx_q;
  assign ball_pos_y       = by_q;
  assign score_left       = sl_q;
  assign score_right      = sr_q;
  assign game_state       = state_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine: directed and random frames against a simple game model.
module tb_pong_game_engine;

  localparam int PADDLE_VEL  = 3;
  localparam int BALL_VEL    = 2;
  localparam int POINT_DELAY = 60;
  localparam int WIN_SCORE   = 9;

  localparam int PH_SERVE = 0;
  localparam int PH_PLAY  = 1;
  localparam int PH_POINT = 2;
  localparam int PH_OVER  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refresh_tick = 1'b0;
  logic       btn_left_up = 1'b0;
  logic       btn_left_down = 1'b0;
  logic       btn_right_up = 1'b0;
  logic       btn_right_down = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] paddle_left_pos, paddle_right_pos, ball_pos_x, ball_pos_y;
  logic [3:0] score_left, score_right;
  logic [1:0] game_state;

  int n_compared = 0;
  int n_mismatched = 0;

  // Game model: positions as plain integers, ball velocity as signed pixels/frame.
  int m_left_pad, m_right_pad, m_ball_x, m_ball_y, m_vel_x, m_vel_y;
  int m_score_left, m_score_right, m_phase, m_frames_in_point, m_last_scorer;

  always #5 clk = ~clk;

  pong_game_engine dut (
    .clk              (clk),
    .reset            (reset),
    .refresh_tick     (refresh_tick),
    .btn_left_up      (btn_left_up),
    .btn_left_down    (btn_left_down),
    .btn_right_up     (btn_right_up),
    .btn_right_down   (btn_right_down),
    .serve            (serve),
    .paddle_left_pos  (paddle_left_pos),
    .paddle_right_pos (paddle_right_pos),
    .ball_pos_x       (ball_pos_x),
    .ball_pos_y       (ball_pos_y),
    .score_left       (score_left),
    .score_right      (score_right),
    .game_state       (game_state)
  );

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int clampInt(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic centreBall();
    m_ball_x = 315;
    m_ball_y = 235;
  endtask

  task automatic modelReset();
    m_left_pad        = 215;
    m_right_pad       = 215;
    centreBall();
    m_vel_x           = BALL_VEL;
    m_vel_y           = BALL_VEL;
    m_score_left      = 0;
    m_score_right     = 0;
    m_phase           = PH_SERVE;
    m_frames_in_point = 0;
    m_last_scorer     = 0;
  endtask

  // who: 0 = left player scored, 1 = right player scored
  task automatic scorePoint(input int who);
    m_last_scorer = who;
    if (who == 0 && m_score_left < WIN_SCORE) m_score_left++;
    if (who == 1 && m_score_right < WIN_SCORE) m_score_right++;
    m_phase = PH_POINT;
    m_frames_in_point = 0;
  endtask

  task automatic modelTick(input logic lu, input logic ld, input logic ru,
                           input logic rd, input logic sv);
    int  old_left, old_right, old_y;
    bit  span_left, span_right;
    old_left  = m_left_pad;
    old_right = m_right_pad;
    old_y     = m_ball_y;
    if (m_phase == PH_SERVE || m_phase == PH_PLAY) begin
      m_left_pad  = clampInt(m_left_pad + PADDLE_VEL * (int'(ld) - int'(lu)), 0, 430);
      m_right_pad = clampInt(m_right_pad + PADDLE_VEL * (int'(rd) - int'(ru)), 0, 430);
    end
    case (m_phase)
      PH_SERVE: if (sv) m_phase = PH_PLAY;
      PH_PLAY: begin
        m_ball_y = old_y + m_vel_y;
        if (m_ball_y <= 0) begin
          m_ball_y = 0;
          m_vel_y  = BALL_VEL;
        end else if (m_ball_y >= 470) begin
          m_ball_y = 470;
          m_vel_y  = -BALL_VEL;
        end
        span_left  = (old_y + 10 > old_left) && (old_y < old_left + 50);
        span_right = (old_y + 10 > old_right) && (old_y < old_right + 50);
        if (m_vel_x < 0) begin
          if (m_ball_x >= 16 && m_ball_x <= 16 + BALL_VEL && span_left) begin
            m_ball_x = 16;
            m_vel_x  = BALL_VEL;
          end else if (m_ball_x <= BALL_VEL) scorePoint(1);
          else m_ball_x += m_vel_x;
        end else begin
          if (m_ball_x >= 610 - BALL_VEL && m_ball_x <= 610 && span_right) begin
            m_ball_x = 610;
            m_vel_x  = -BALL_VEL;
          end else if (m_ball_x + BALL_VEL >= 630) scorePoint(0);
          else m_ball_x += m_vel_x;
        end
      end
      PH_POINT: begin
        m_frames_in_point++;
        if (m_frames_in_point == POINT_DELAY) begin
          if ((m_last_scorer == 0 ? m_score_left : m_score_right) == WIN_SCORE) begin
            m_phase = PH_OVER;
          end else begin
            m_phase = PH_SERVE;
            centreBall();
            m_vel_y = BALL_VEL;
            m_vel_x = (m_last_scorer == 0) ? BALL_VEL : -BALL_VEL;
          end
        end
      end
      default: begin
        if (sv) begin
          m_phase       = PH_SERVE;
          m_score_left  = 0;
          m_score_right = 0;
          m_left_pad    = 215;
          m_right_pad   = 215;
          centreBall();
          m_vel_y       = BALL_VEL;
        end
      end
    endcase
  endtask

  task automatic checkOutput();
    checkValue("paddle_left", 32'(paddle_left_pos), m_left_pad);
    checkValue("paddle_right", 32'(paddle_right_pos), m_right_pad);
    checkValue("ball_x", 32'(ball_pos_x), m_ball_x);
    checkValue("ball_y", 32'(ball_pos_y), m_ball_y);
    checkValue("score_left", 32'(score_left), m_score_left);
    checkValue("score_right", 32'(score_right), m_score_right);
    checkValue("game_state", 32'(game_state), m_phase);
  endtask

  task automatic applyStimulus(input logic tick, input logic lu, input logic ld,
                               input logic ru, input logic rd, input logic sv,
                               input logic rst);
    @(negedge clk);
    refresh_tick   = tick;
    btn_left_up    = lu;
    btn_left_down  = ld;
    btn_right_up   = ru;
    btn_right_down = rd;
    serve          = sv;
    reset          = rst;
    @(posedge clk);
    #1;
    if (rst) modelReset();
    else if (tick) modelTick(lu, ld, ru, rd, sv);
    checkOutput();
  endtask

  initial begin
    logic [3:0] buttons;
    logic       rnd_tick, rnd_serve, rnd_rst;
    int         guard;

    $display("[TB] pong_game_engine bench start");
    modelReset();

    // Reset, including reset beating a simultaneous tick with buttons and serve.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkValue("reset_state", 32'(game_state), 0);
    checkValue("reset_paddle", 32'(paddle_left_pos), 215);

    // Paddle clamping in SERVE.
    repeat (80) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("clamp_top", 32'(paddle_left_pos), 0);
    repeat (200) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("clamp_bottom", 32'(paddle_left_pos), 430);
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkValue("both_hold", 32'(paddle_left_pos), 430);
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkValue("no_tick_hold", 32'(paddle_left_pos), 430);
    checkValue("no_tick_state", 32'(game_state), 0);

    // Bounce off the bottom wall, then right paddle hit at 401.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (62) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkValue("right_pad_401", 32'(paddle_right_pos), 401);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkValue("serve_no_move", 32'(ball_pos_x), 315);
    for (int t = 1; t <= 149; t++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (t == 117) checkValue("y_t117", 32'(ball_pos_y), 469);
      if (t == 118) checkValue("y_t118", 32'(ball_pos_y), 470);
      if (t == 118) checkValue("x_t118", 32'(ball_pos_x), 551);
      if (t == 119) checkValue("y_t119", 32'(ball_pos_y), 468);
      if (t == 148) checkValue("hit_x", 32'(ball_pos_x), 610);
      if (t == 148) checkValue("hit_y", 32'(ball_pos_y), 410);
      if (t == 149) checkValue("rebound_x", 32'(ball_pos_x), 608);
    end

    // Reset mid-PLAY.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkValue("midplay_reset_pr", 32'(paddle_right_pos), 215);
    checkValue("midplay_reset_x", 32'(ball_pos_x), 315);
    checkValue("midplay_reset_state", 32'(game_state), 0);

    // Right miss, frozen point delay with serve ignored, then re-serve.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 158; t++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (t == 157) checkValue("miss_x157", 32'(ball_pos_x), 629);
    end
    checkValue("miss_state", 32'(game_state), 2);
    checkValue("miss_score", 32'(score_left), 1);
    checkValue("miss_frozen_x", 32'(ball_pos_x), 629);
    repeat (59) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkValue("point_hold_state", 32'(game_state), 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("point_expiry_state", 32'(game_state), 0);
    checkValue("recentre_y", 32'(ball_pos_y), 235);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Left keeps scoring until the game ends; serve held throughout.
    guard = 0;
    while (m_phase != PH_OVER && guard < 3000) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    checkValue("game_over_state", 32'(game_state), 3);
    checkValue("game_over_score", 32'(score_left), 9);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkValue("restart_score", 32'(score_left), 0);
    checkValue("restart_state", 32'(game_state), 0);

    // Random frames, ticks, serves and occasional resets.
    buttons = '0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 16 == 0) buttons = 4'($urandom_range(0, 15));
      rnd_tick  = ($urandom_range(0, 3) != 0);
      rnd_serve = ($urandom_range(0, 7) == 0);
      rnd_rst   = ($urandom_range(0, 999) == 0);
      applyStimulus(rnd_tick, buttons[0], buttons[1], buttons[2], buttons[3],
                    rnd_serve, rnd_rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
